// File: rtl/cpu4_bus_memory_if.sv
// cpu4_bus_memory_if: CPU bus and host-loader signal bundle for cpu4_bus_memory.
//   master: drives bus_addr/bus_wcyc and load_en/load_valid/load_data.
//   slave : drives bus_rdata, load_ready/load_ptr/load_done, cpu_rst_p, proto_err, wr_count.
interface cpu4_bus_memory_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wcyc;
    logic [DATA_W-1:0] bus_rdata;
    logic              load_en;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] load_ptr;
    logic              load_done;
    logic              cpu_rst_p;
    logic              proto_err;
    logic [7:0]        wr_count;

    modport master (
        output bus_addr, bus_wcyc, load_en, load_valid, load_data,
        input  bus_rdata, load_ready, load_ptr, load_done, cpu_rst_p, proto_err, wr_count
    );

    modport slave (
        input  bus_addr, bus_wcyc, load_en, load_valid, load_data,
        output bus_rdata, load_ready, load_ptr, load_done, cpu_rst_p, proto_err, wr_count
    );
endinterface

// File: rtl/cpu4_bus_memory.sv
// cpu4_bus_memory: 128x4 memory responder for the 4-bit CPU bus with host program loader.
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset; clears memory and all control state.
//   bus   : slave side of cpu4_bus_memory_if (two-phase CPU writes, combinational reads,
//           host load port, CPU reset, sticky protocol error, saturating write counter).
module cpu4_bus_memory #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 128
) (
    input logic                clk,
    input logic                rst_n,
    cpu4_bus_memory_if.slave   bus
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              load_done_q, load_done_d;
    logic              proto_err_q, proto_err_d;
    logic [7:0]        wr_count_q, wr_count_d;
    logic              cpu_rst_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        load_ptr_d  = load_ptr_q;
        load_done_d = load_done_q;
        proto_err_d = proto_err_q;
        wr_count_d  = wr_count_q;
        we          = 1'b0;
        wa          = waddr_q;
        wd          = bus.bus_addr[DATA_W-1:0];
        if (state_q == S_LOAD) begin
            if (!bus.load_en) begin
                state_d = S_RUN;
            end else if (bus.load_valid) begin
                we          = 1'b1;
                wa          = load_ptr_q;
                wd          = bus.load_data;
                load_ptr_d  = load_ptr_q + ADDR_W'(1);
                load_done_d = load_done_q | (&load_ptr_q);
            end
        end else if (bus.load_en) begin
            // Load request wins over any bus activity, including a pending data phase.
            state_d     = S_LOAD;
            load_ptr_d  = '0;
            load_done_d = 1'b0;
            wr_count_d  = '0;
        end else if (state_q == S_WDATA) begin
            state_d = S_RUN;
            if (bus.bus_wcyc) begin
                we         = 1'b1;
                wr_count_d = wr_count_q + {7'd0, ~&wr_count_q};
            end else begin
                proto_err_d = 1'b1;
            end
        end else if (bus.bus_wcyc) begin
            waddr_d = bus.bus_addr;
            state_d = S_WDATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            waddr_q     <= '0;
            load_ptr_q  <= '0;
            load_done_q <= 1'b0;
            proto_err_q <= 1'b0;
            wr_count_q  <= '0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            load_ptr_q  <= load_ptr_d;
            load_done_q <= load_done_d;
            proto_err_q <= proto_err_d;
            wr_count_q  <= wr_count_d;
            cpu_rst_q   <= (state_d == S_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    // Reads are combinational so a write's new value appears only after its edge.
    assign bus.bus_rdata  = (state_q == S_LOAD) ? '0 : mem_q[bus.bus_addr];
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.load_ptr   = load_ptr_q;
    assign bus.load_done  = load_done_q;
    assign bus.cpu_rst_p  = cpu_rst_q;
    assign bus.proto_err  = proto_err_q;
    assign bus.wr_count   = wr_count_q;
endmodule
